// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
//   Shared types and constants for the BCD stopwatch controller.
//   - state_e     : sequencer states (2-bit encoding, all codes used)
//   - BCD_MAX     : largest legal decimal digit value
//   - NDIG        : number of cascaded decades in the count chain
//   - is_counting : true in the states where the prescaler runs
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int         NDIG    = 4;

  // RUN and LAP both keep time; LAP only changes what the display shows.
  function automatic logic is_counting(input state_e s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
//   One decade of the cascaded BCD count chain.
//   Ports:
//     clock  in   rising-edge clock
//     reset  in   asynchronous active-low reset
//     clr    in   synchronous clear to 0
//     inc    in   advance this digit by one
//     q      out  current digit value
//     carry  out  inc while at 9: advance the next decade this cycle
// -----------------------------------------------------------------------------
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_q;

  // Decade register; a corrupted value above 9 falls back to 0 on the next advance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q <= 4'd0;
    end else if (clr) begin
      q_q <= 4'd0;
    end else if (inc) begin
      if (q_q >= BCD_MAX) begin
        q_q <= 4'd0;
      end else begin
        q_q <= q_q + 4'd1;
      end
    end
  end

  assign q     = q_q;
  assign carry = inc & (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_stopwatch_ctrl
//   Stopwatch sequencer driving a 4-digit BCD count chain: start/pause,
//   lap freeze and clear, with a prescaler producing count ticks.
//   Parameter:
//     TICK_DIV    clock cycles per count tick (>= 1)
//   Ports:
//     clock       in   rising-edge clock
//     reset       in   asynchronous active-low reset
//     start_stop  in   pulse: toggle run/pause
//     lap         in   pulse: freeze/unfreeze display while counting goes on
//     clear       in   pulse: back to IDLE with count 0000
//     display     out  {d3,d2,d1,d0}; lap latch in LAP, live count otherwise
//     running     out  1 in RUN or LAP
//     lap_active  out  1 in LAP
//     overflow    out  sticky 9999->0000 wrap flag
//     tick        out  1-cycle pulse on the cycle whose edge advances the count
// -----------------------------------------------------------------------------
module bcd_stopwatch_ctrl
  import bcd_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  output logic [15:0] display,
  output logic        running,
  output logic        lap_active,
  output logic        overflow,
  output logic        tick
);

  localparam int            PW        = $clog2(TICK_DIV) + 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);

  state_e            state_q;
  logic [PW-1:0]     presc_q;
  logic [15:0]       latch_q;
  logic              ovf_q;
  logic [15:0]       count_s;
  logic              tick_s;
  logic [NDIG-1:0]   inc_s;
  logic [NDIG-1:0]   carry_s;

  // A clear in the same cycle suppresses the increment, so no tick is reported.
  assign tick_s = is_counting(state_q) && (presc_q == PRESC_MAX) && !clear;

  // Count chain: each decade advances on the carry of the one below it.
  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    if (g == 0) begin : g_first
      assign inc_s[g] = tick_s;
    end else begin : g_next
      assign inc_s[g] = carry_s[g-1];
    end
    bcd_digit u_digit (
      .clock (clock),
      .reset (reset),
      .clr   (clear),
      .inc   (inc_s[g]),
      .q     (count_s[4*g +: 4]),
      .carry (carry_s[g])
    );
  end

  // Sequencer; clear beats start_stop, which beats lap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else if (clear) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:  if (start_stop) state_q <= RUN;
        RUN:   if (start_stop) state_q <= PAUSE;
               else if (lap)   state_q <= LAP;
        LAP:   if (start_stop) state_q <= PAUSE;
               else if (lap)   state_q <= RUN;
        PAUSE: if (start_stop) state_q <= RUN;
        default:               state_q <= IDLE;
      endcase
    end
  end

  // Prescaler: held in PAUSE so the tick phase survives a pause/resume.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else if (clear || (state_q == IDLE)) begin
      presc_q <= '0;
    end else if (is_counting(state_q)) begin
      if (presc_q == PRESC_MAX) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + PRESC_ONE;
      end
    end
  end

  // Lap latch samples the pre-increment count when entering LAP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      latch_q <= 16'h0000;
    end else if (clear) begin
      latch_q <= 16'h0000;
    end else if ((state_q == RUN) && lap && !start_stop) begin
      latch_q <= count_s;
    end
  end

  // Sticky overflow: carry out of the top decade means 9999 -> 0000.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (clear) begin
      ovf_q <= 1'b0;
    end else if (carry_s[NDIG-1]) begin
      ovf_q <= 1'b1;
    end
  end

  assign display    = (state_q == LAP) ? latch_q : count_s;
  assign running    = is_counting(state_q);
  assign lap_active = (state_q == LAP);
  assign overflow   = ovf_q;
  assign tick       = tick_s;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bcd_stopwatch_ctrl
//   Two instances (TICK_DIV=4 and TICK_DIV=1) share the same stimulus. A
//   behavioural model (integer count, integer prescaler phase) predicts every
//   output and is compared on each falling edge; directed scenarios add
//   literal expectations.
// -----------------------------------------------------------------------------
module tb_bcd_stopwatch_ctrl;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_LAP   = 3;

  typedef struct packed {
    int st;
    int cnt;
    int latch;
    int pre;
    bit ovf;
  } m_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ss_i, lp_i, cl_i;
  logic [15:0] disp0, disp1;
  logic        run0, run1, lapa0, lapa1, ovf0, ovf1, tick0, tick1;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  m_t m0, m1;

  always #5 clk = ~clk;

  bcd_stopwatch_ctrl #(.TICK_DIV(4)) u_dut4 (
    .clock(clk), .reset(rst_n), .start_stop(ss_i), .lap(lp_i), .clear(cl_i),
    .display(disp0), .running(run0), .lap_active(lapa0), .overflow(ovf0), .tick(tick0)
  );

  bcd_stopwatch_ctrl #(.TICK_DIV(1)) u_dut1 (
    .clock(clk), .reset(rst_n), .start_stop(ss_i), .lap(lp_i), .clear(cl_i),
    .display(disp1), .running(run1), .lap_active(lapa1), .overflow(ovf1), .tick(tick1)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic bit counting(input m_t m);
    return (m.st == S_RUN) || (m.st == S_LAP);
  endfunction

  function automatic bit m_tick(input m_t m, input int div, input bit cl);
    return counting(m) && (m.pre == div - 1) && !cl;
  endfunction

  function automatic m_t next_m(input m_t m, input int div, input bit ss, input bit lp, input bit cl);
    m_t r = m;
    bit adv = m_tick(m, div, cl);
    if (cl) begin
      r = '0;
      r.st = S_IDLE;
    end else begin
      if (counting(m)) r.pre = adv ? 0 : m.pre + 1;
      else if (m.st == S_IDLE) r.pre = 0;
      if (adv) begin
        if (m.cnt == 9999) r.ovf = 1'b1;
        r.cnt = (m.cnt + 1) % 10000;
      end
      case (m.st)
        S_IDLE:  if (ss) r.st = S_RUN;
        S_RUN:   if (ss) r.st = S_PAUSE;
                 else if (lp) begin r.st = S_LAP; r.latch = m.cnt; end
        S_LAP:   if (ss) r.st = S_PAUSE;
                 else if (lp) r.st = S_RUN;
        S_PAUSE: if (ss) r.st = S_RUN;
        default: r.st = S_IDLE;
      endcase
    end
    return r;
  endfunction

  // Reference model state, reset asynchronously like the design.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= next_m(m0, 4, ss_i, lp_i, cl_i);
      m1 <= next_m(m1, 1, ss_i, lp_i, cl_i);
    end
  end

  task automatic cmp_dut(input string tag, input m_t m, input int div, input logic [15:0] d,
                         input logic r, input logic l, input logic o, input logic t);
    chk({tag, ".display"},    int'(d), int'(to_bcd((m.st == S_LAP) ? m.latch : m.cnt)));
    chk({tag, ".running"},    int'(r), int'(counting(m)));
    chk({tag, ".lap_active"}, int'(l), int'(m.st == S_LAP));
    chk({tag, ".overflow"},   int'(o), int'(m.ovf));
    chk({tag, ".tick"},       int'(t), int'(m_tick(m, div, cl_i)));
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("div4", m0, 4, disp0, run0, lapa0, ovf0, tick0);
      cmp_dut("div1", m1, 1, disp1, run1, lapa1, ovf1, tick1);
    end
  end

  task automatic drive(input bit ss, input bit lp, input bit cl);
    ss_i = ss; lp_i = lp; cl_i = cl;
    @(posedge clk); #1;
    ss_i = 1'b0; lp_i = 1'b0; cl_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int nt;
    logic [15:0] cur, prev;
    rst_n = 1'b0; ss_i = 1'b0; lp_i = 1'b0; cl_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // reset values
    chk("rst.display", int'(disp0), 16'h0000);
    chk("rst.running", int'(run0), 0);
    chk("rst.overflow", int'(ovf0), 0);
    chk("rst.tick", int'(tick0), 0);

    // run 40 cycles: 10 ticks, 0009 -> 0010 carry
    drive(1'b1, 1'b0, 1'b0);
    nt = 0; cur = disp0; prev = disp0;
    repeat (40) begin
      @(posedge clk); #1;
      prev = cur; cur = disp0;
      if (tick0) nt++;
    end
    chk("run.ticks", nt, 10);
    chk("run.before_carry", int'(prev), 16'h0009);
    chk("run.after_carry", int'(cur), 16'h0010);

    // lap at 0012, held while counting goes on, released at 0020
    idle(8);
    chk("lap.pre", int'(disp0), 16'h0012);
    drive(1'b0, 1'b1, 1'b0);
    chk("lap.active", int'(lapa0), 1);
    idle(32);
    chk("lap.held", int'(disp0), 16'h0012);
    drive(1'b0, 1'b1, 1'b0);
    chk("lap.release", int'(disp0), 16'h0020);
    chk("lap.inactive", int'(lapa0), 0);

    // pause at 0005 two cycles after its tick, then resume keeps the phase
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    idle(20);
    chk("pause.at5", int'(disp0), 16'h0005);
    idle(1);
    drive(1'b1, 1'b0, 1'b0);
    nt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (tick0) nt++;
    end
    chk("pause.no_tick", nt, 0);
    chk("pause.hold", int'(disp0), 16'h0005);
    chk("pause.running", int'(run0), 0);
    drive(1'b1, 1'b0, 1'b0);
    chk("resume.tick_c1", int'(tick0), 0);
    idle(1);
    chk("resume.tick_c2", int'(tick0), 1);
    idle(1);
    chk("resume.count", int'(disp0), 16'h0006);

    // clear + start_stop together at 0037
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    idle(148);
    chk("clr.pre", int'(disp0), 16'h0037);
    drive(1'b1, 1'b0, 1'b1);
    chk("clr.display", int'(disp0), 16'h0000);
    chk("clr.running", int'(run0), 0);

    // tick + lap together at 0007 -> 0008 latches 0007
    drive(1'b1, 1'b0, 1'b0);
    idle(28);
    chk("tlap.pre", int'(disp0), 16'h0007);
    idle(3);
    chk("tlap.tick", int'(tick0), 1);
    drive(1'b0, 1'b1, 1'b0);
    chk("tlap.latch", int'(disp0), 16'h0007);
    chk("tlap.active", int'(lapa0), 1);
    idle(4);
    drive(1'b1, 1'b0, 1'b0);
    chk("lap_pause.live", int'(disp0), 16'h0009);
    chk("lap_pause.running", int'(run0), 0);

    // TICK_DIV=1: wrap 9999 -> 0000, sticky overflow, cleared by clear
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    idle(9999);
    chk("wrap.9999", int'(disp1), 16'h9999);
    chk("wrap.no_ovf", int'(ovf1), 0);
    idle(1);
    chk("wrap.0000", int'(disp1), 16'h0000);
    chk("wrap.ovf", int'(ovf1), 1);
    idle(5);
    chk("wrap.ovf_held", int'(ovf1), 1);
    drive(1'b0, 1'b0, 1'b1);
    chk("wrap.ovf_clr", int'(ovf1), 0);
    chk("wrap.idle", int'(run1), 0);

    // reset mid-run with overflow set: outputs drop without a clock edge
    drive(1'b1, 1'b0, 1'b0);
    idle(10003);
    chk("arst.pre_ovf", int'(ovf1), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.display0", int'(disp0), 16'h0000);
    chk("arst.running0", int'(run0), 0);
    chk("arst.display1", int'(disp1), 16'h0000);
    chk("arst.overflow1", int'(ovf1), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // randomized pulses against the model
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      ss_i = ($urandom_range(0, 15) == 0);
      lp_i = ($urandom_range(0, 9) == 0);
      cl_i = ($urandom_range(0, 79) == 0);
      @(posedge clk); #1;
    end
    ss_i = 1'b0; lp_i = 1'b0; cl_i = 1'b0;
    idle(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
